// File: rtl/resp_checker_pkg.sv
// resp_checker_pkg
//   Shared types and defaults for the response checker.
//   state_e             : run-control FSM encoding
//   DEFAULT_NUM_VECTORS : sample pairs per run (4 directed + 500 random)
package resp_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_NUM_VECTORS = 504;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   inc_i  : count up by one (ignored once saturated)
//   clr_i  : synchronous clear, wins over inc_i
//   cnt_o  : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/resp_checker.sv
// resp_checker
//   Pairs golden-model and netlist samples, compares them bit-exactly and
//   accumulates match/mismatch statistics over a run of NUM_VECTORS pairs.
//
//   state | meaning
//   IDLE  | waiting for start, no pairs accepted
//   RUN   | accepting one pair per cycle, compare stage active
//   DONE  | results held until reset or the next start
//
//   clk, rst_n             : clock, async active-low reset
//   start                  : begin (or restart) a run from IDLE/DONE
//   in_valid/in_ready      : pair handshake, golden/netlist carry the pair
//   busy, done, pass       : run status
//   match_cnt/mismatch_cnt : saturating result counters
//   first_mm_valid/_idx    : index of the first differing pair
//   mm_pulse               : one-cycle strobe per mismatch
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int NUM_VECTORS = DEFAULT_NUM_VECTORS,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] netlist,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_mm_valid,
  output logic [CNT_W-1:0] first_mm_idx,
  output logic             mm_pulse
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic             stage_vld_q;
  logic [WIDTH-1:0] stage_gold_q, stage_net_q;
  logic [CNT_W-1:0] stage_idx_q;
  logic             final_q;
  logic             mm_pulse_q;
  logic             first_mm_valid_q;
  logic [CNT_W-1:0] first_mm_idx_q;
  logic [CNT_W-1:0] vec_idx;

  logic run, clr, xfer, last_xfer, stage_eq, stage_mm;

  assign run       = (state_q == RUN);
  assign clr       = start && !run;
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (vec_idx == LAST_IDX);
  assign stage_eq  = stage_vld_q && (stage_gold_q == stage_net_q);
  assign stage_mm  = stage_vld_q && (stage_gold_q != stage_net_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave RUN only once the final pair has drained from the
  // compare stage, so done never precedes the last counter update.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (final_q && !stage_vld_q) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready = run && !final_q;
    busy     = run;
    done     = (state_q == DONE);
    pass     = (state_q == DONE) && (mismatch_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld_q      <= 1'b0;
      stage_gold_q     <= '0;
      stage_net_q      <= '0;
      stage_idx_q      <= '0;
      final_q          <= 1'b0;
      mm_pulse_q       <= 1'b0;
      first_mm_valid_q <= 1'b0;
      first_mm_idx_q   <= '0;
    end else begin
      stage_vld_q <= xfer;
      if (xfer) begin
        stage_gold_q <= golden;
        stage_net_q  <= netlist;
        stage_idx_q  <= vec_idx;
      end
      mm_pulse_q <= stage_mm;
      if (clr) begin
        final_q          <= 1'b0;
        first_mm_valid_q <= 1'b0;
        first_mm_idx_q   <= '0;
      end else begin
        if (last_xfer) final_q <= 1'b1;
        if (stage_mm && !first_mm_valid_q) begin
          first_mm_valid_q <= 1'b1;
          first_mm_idx_q   <= stage_idx_q;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk_i (clk), .rst_ni(rst_n), .inc_i(stage_eq), .clr_i(clr), .cnt_o(match_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
    .clk_i (clk), .rst_ni(rst_n), .inc_i(stage_mm), .clr_i(clr), .cnt_o(mismatch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_vec_idx (
    .clk_i (clk), .rst_ni(rst_n), .inc_i(xfer), .clr_i(clr), .cnt_o(vec_idx)
  );

  assign mm_pulse       = mm_pulse_q;
  assign first_mm_valid = first_mm_valid_q;
  assign first_mm_idx   = first_mm_idx_q;

endmodule

// File: tb/tb_resp_checker.sv
module tb_resp_checker;

  logic clk, rst_n;
  int   checks = 0;
  int   errors = 0;

  // DUT A: 4-vector run
  logic        a_start, a_valid, a_rdy, a_busy, a_done, a_pass, a_fmv, a_mmp;
  logic [0:0]  a_g, a_n;
  logic [15:0] a_mc, a_mmc, a_fmi;

  // DUT B: full 504-vector run
  logic        b_start, b_valid, b_rdy, b_busy, b_done, b_pass, b_fmv, b_mmp;
  logic [0:0]  b_g, b_n;
  logic [15:0] b_mc, b_mmc, b_fmi;

  // DUT C: 3-bit counters, 7 vectors
  logic        c_start, c_valid, c_rdy, c_busy, c_done, c_pass, c_fmv, c_mmp;
  logic [0:0]  c_g, c_n;
  logic [2:0]  c_mc, c_mmc, c_fmi;

  // Standalone saturating counter
  logic        s_inc, s_clr;
  logic [2:0]  s_cnt;

  resp_checker #(.WIDTH(1), .NUM_VECTORS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(a_rdy),
    .golden(a_g), .netlist(a_n), .busy(a_busy), .done(a_done), .pass(a_pass),
    .match_cnt(a_mc), .mismatch_cnt(a_mmc), .first_mm_valid(a_fmv),
    .first_mm_idx(a_fmi), .mm_pulse(a_mmp)
  );

  resp_checker #(.WIDTH(1), .NUM_VECTORS(504), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_rdy),
    .golden(b_g), .netlist(b_n), .busy(b_busy), .done(b_done), .pass(b_pass),
    .match_cnt(b_mc), .mismatch_cnt(b_mmc), .first_mm_valid(b_fmv),
    .first_mm_idx(b_fmi), .mm_pulse(b_mmp)
  );

  resp_checker #(.WIDTH(1), .NUM_VECTORS(7), .CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_valid), .in_ready(c_rdy),
    .golden(c_g), .netlist(c_n), .busy(c_busy), .done(c_done), .pass(c_pass),
    .match_cnt(c_mc), .mismatch_cnt(c_mmc), .first_mm_valid(c_fmv),
    .first_mm_idx(c_fmi), .mm_pulse(c_mmp)
  );

  sat_counter #(.CNT_W(3)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .inc_i(s_inc), .clr_i(s_clr), .cnt_o(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one 4-pair run on DUT A (bit i of g/n is pair i). Called #1 after an edge.
  task automatic a_run(input logic [3:0] g, input logic [3:0] n, input bit mid_start,
                       output int pulses, output int lat, output logic rdy_after_last,
                       output int snap_cnt, output logic snap_fmv,
                       output logic snap_busy, output logic snap_done);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start   = 1'b0;
    snap_cnt  = int'(a_mc) + int'(a_mmc);
    snap_fmv  = a_fmv;
    snap_busy = a_busy;
    snap_done = a_done;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_g     = g[i];
      a_n     = n[i];
      a_start = mid_start && (i == 2);
      @(posedge clk); #1;
      if (a_mmp) pulses++;
    end
    a_start        = 1'b0;
    rdy_after_last = a_rdy;
    a_valid        = 1'b0;
    lat = 0;
    while (!a_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (a_mmp) pulses++;
    end
  endtask

  task automatic test_reset();
    checks++; if (a_rdy !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", a_rdy); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
    checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", a_pass); end
    checks++; if (a_mc !== 16'd0 || a_mmc !== 16'd0 || a_fmi !== 16'd0)
      begin errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", a_mc, a_mmc, a_fmi); end
    checks++; if (a_fmv !== 1'b0 || a_mmp !== 1'b0)
      begin errors++; $display("FAIL reset_flags got fmv=%b mmp=%b exp=0/0", a_fmv, a_mmp); end
    // in_valid in IDLE must not be taken
    a_valid = 1'b1; a_g = 1'b1; a_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (a_mmc !== 16'd0 || a_mc !== 16'd0)
      begin errors++; $display("FAIL idle_ignore_valid got=%0d/%0d exp=0/0", a_mc, a_mmc); end
  endtask

  task automatic test_all_match();
    int p, l, sc; logic r, sf, sb, sd;
    a_run(4'b1000, 4'b1000, 1'b0, p, l, r, sc, sf, sb, sd);
    checks++; if (sb !== 1'b1) begin errors++; $display("FAIL match_busy_after_start got=%b exp=1", sb); end
    checks++; if (r !== 1'b0)  begin errors++; $display("FAIL match_ready_after_last got=%b exp=0", r); end
    checks++; if (l != 2)      begin errors++; $display("FAIL match_done_latency got=%0d exp=2", l); end
    checks++; if (a_mc !== 16'd4)  begin errors++; $display("FAIL match_cnt got=%0d exp=4", a_mc); end
    checks++; if (a_mmc !== 16'd0) begin errors++; $display("FAIL match_mismatch_cnt got=%0d exp=0", a_mmc); end
    checks++; if (a_pass !== 1'b1 || a_busy !== 1'b0 || a_rdy !== 1'b0)
      begin errors++; $display("FAIL match_status got pass=%b busy=%b rdy=%b exp=1/0/0", a_pass, a_busy, a_rdy); end
    checks++; if (p != 0 || a_fmv !== 1'b0)
      begin errors++; $display("FAIL match_no_mm got pulses=%0d fmv=%b exp=0/0", p, a_fmv); end
  endtask

  task automatic test_mismatch();
    int p, l, sc; logic r, sf, sb, sd;
    // starts from DONE of the previous run: clear happens on the start edge
    a_run(4'b1000, 4'b0010, 1'b0, p, l, r, sc, sf, sb, sd);
    checks++; if (sc != 0 || sb !== 1'b1 || sd !== 1'b0)
      begin errors++; $display("FAIL restart_clear got cnt=%0d busy=%b done=%b exp=0/1/0", sc, sb, sd); end
    checks++; if (l != 2)           begin errors++; $display("FAIL mm_done_latency got=%0d exp=2", l); end
    checks++; if (a_mmc !== 16'd2)  begin errors++; $display("FAIL mm_mismatch_cnt got=%0d exp=2", a_mmc); end
    checks++; if (a_mc !== 16'd2)   begin errors++; $display("FAIL mm_match_cnt got=%0d exp=2", a_mc); end
    checks++; if (a_fmv !== 1'b1 || a_fmi !== 16'd1)
      begin errors++; $display("FAIL mm_first got fmv=%b idx=%0d exp=1/1", a_fmv, a_fmi); end
    checks++; if (p != 2)           begin errors++; $display("FAIL mm_pulse_count got=%0d exp=2", p); end
    checks++; if (a_pass !== 1'b0 || a_done !== 1'b1)
      begin errors++; $display("FAIL mm_status got pass=%b done=%b exp=0/1", a_pass, a_done); end
  endtask

  task automatic test_back_to_back();
    int p, l, sc; logic r, sf, sb, sd;
    // start from DONE with stale mismatches, plus a start pulse mid-run
    a_run(4'b0101, 4'b0101, 1'b1, p, l, r, sc, sf, sb, sd);
    checks++; if (sc != 0 || sf !== 1'b0)
      begin errors++; $display("FAIL b2b_clear got cnt=%0d fmv=%b exp=0/0", sc, sf); end
    checks++; if (l != 2)          begin errors++; $display("FAIL b2b_done_latency got=%0d exp=2", l); end
    checks++; if (a_mc !== 16'd4 || a_mmc !== 16'd0)
      begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=4/0", a_mc, a_mmc); end
    checks++; if (a_pass !== 1'b1 || a_fmv !== 1'b0 || a_fmi !== 16'd0)
      begin errors++; $display("FAIL b2b_result got pass=%b fmv=%b idx=%0d exp=1/0/0", a_pass, a_fmv, a_fmi); end
  endtask

  task automatic test_random_valid();
    int v, cyc, exp_mm, exp_first, bad_ready, lat;
    logic rdy;
    bit take;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    v = 0; cyc = 0; exp_mm = 0; exp_first = -1; bad_ready = 0;
    b_g = 1'($urandom);
    b_n = ($urandom_range(0, 4) == 0) ? ~b_g : b_g;
    while (v < 504 && cyc < 4000) begin
      b_valid = ($urandom_range(0, 3) != 0);
      rdy = b_rdy;
      if (!rdy) bad_ready++;
      take = b_valid && rdy;
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        if (b_g != b_n) begin
          exp_mm++;
          if (exp_first < 0) exp_first = v;
        end
        v++;
        b_g = 1'($urandom);
        b_n = ($urandom_range(0, 4) == 0) ? ~b_g : b_g;
      end
    end
    checks++; if (v != 504) begin errors++; $display("FAIL rnd_transfers got=%0d exp=504", v); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL rnd_ready_drop got=%0d exp=0", bad_ready); end
    b_valid = 1'b1;
    checks++; if (b_rdy !== 1'b0 || b_done !== 1'b0)
      begin errors++; $display("FAIL rnd_after_last got rdy=%b done=%b exp=0/0", b_rdy, b_done); end
    lat = 0;
    while (!b_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL rnd_done_latency got=%0d exp=2", lat); end
    repeat (3) @(posedge clk); #1;
    b_valid = 1'b0;
    checks++; if (int'(b_mc) + int'(b_mmc) != 504)
      begin errors++; $display("FAIL rnd_sum got=%0d exp=504", int'(b_mc) + int'(b_mmc)); end
    checks++; if (int'(b_mmc) != exp_mm)
      begin errors++; $display("FAIL rnd_mismatch_cnt got=%0d exp=%0d", b_mmc, exp_mm); end
    checks++; if (b_fmv !== (exp_mm > 0) || (exp_mm > 0 && int'(b_fmi) != exp_first))
      begin errors++; $display("FAIL rnd_first got fmv=%b idx=%0d exp_idx=%0d", b_fmv, b_fmi, exp_first); end
    checks++; if (b_pass !== (exp_mm == 0) || b_done !== 1'b1)
      begin errors++; $display("FAIL rnd_status got pass=%b done=%b exp_mm=%0d", b_pass, b_done, exp_mm); end
  endtask

  task automatic test_no_wrap();
    int cyc;
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    c_valid = 1'b1; c_g = 1'b0; c_n = 1'b1;
    cyc = 0;
    while (!c_done && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (c_done !== 1'b1) begin errors++; $display("FAIL nowrap_done got=%b exp=1", c_done); end
    checks++; if (c_mmc !== 3'd7 || c_mc !== 3'd0)
      begin errors++; $display("FAIL nowrap_counts got=%0d/%0d exp=0/7", c_mc, c_mmc); end
    checks++; if (c_fmv !== 1'b1 || c_fmi !== 3'd0 || c_pass !== 1'b0)
      begin errors++; $display("FAIL nowrap_first got fmv=%b idx=%0d pass=%b exp=1/0/0", c_fmv, c_fmi, c_pass); end
    repeat (3) @(posedge clk); #1;
    c_valid = 1'b0;
    checks++; if (c_mmc !== 3'd7) begin errors++; $display("FAIL nowrap_hold got=%0d exp=7", c_mmc); end
  endtask

  task automatic test_saturation();
    s_clr = 1'b1;
    @(posedge clk); #1;
    s_clr = 1'b0;
    checks++; if (s_cnt !== 3'd0) begin errors++; $display("FAIL sat_clear got=%0d exp=0", s_cnt); end
    s_inc = 1'b1;
    repeat (5) @(posedge clk); #1;
    checks++; if (s_cnt !== 3'd5) begin errors++; $display("FAIL sat_count got=%0d exp=5", s_cnt); end
    repeat (6) @(posedge clk); #1;
    checks++; if (s_cnt !== 3'd7) begin errors++; $display("FAIL sat_hold got=%0d exp=7", s_cnt); end
    s_clr = 1'b1;
    @(posedge clk); #1;
    s_clr = 1'b0; s_inc = 1'b0;
    checks++; if (s_cnt !== 3'd0) begin errors++; $display("FAIL sat_clr_priority got=%0d exp=0", s_cnt); end
  endtask

  task automatic test_reset_midrun();
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_valid = 1'b1; b_g = 1'b1; b_n = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++; if (b_mmc !== 16'd9 || b_busy !== 1'b1)
      begin errors++; $display("FAIL midrun_pre got mm=%0d busy=%b exp=9/1", b_mmc, b_busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (b_rdy !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_pass !== 1'b0)
      begin errors++; $display("FAIL midrun_rst_status got rdy=%b busy=%b done=%b pass=%b exp=0", b_rdy, b_busy, b_done, b_pass); end
    checks++; if (b_mc !== 16'd0 || b_mmc !== 16'd0 || b_fmi !== 16'd0 || b_fmv !== 1'b0 || b_mmp !== 1'b0)
      begin errors++; $display("FAIL midrun_rst_results got mc=%0d mm=%0d fmi=%0d fmv=%b mmp=%b exp=0", b_mc, b_mmc, b_fmi, b_fmv, b_mmp); end
    b_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (b_mmc !== 16'd0 || b_rdy !== 1'b0 || b_busy !== 1'b0)
      begin errors++; $display("FAIL midrun_after_release got mm=%0d rdy=%b busy=%b exp=0/0/0", b_mmc, b_rdy, b_busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_valid = 0; a_g = 0; a_n = 0;
    b_start = 0; b_valid = 0; b_g = 0; b_n = 0;
    c_start = 0; c_valid = 0; c_g = 0; c_n = 0;
    s_inc = 0; s_clr = 0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_all_match();
    test_mismatch();
    test_back_to_back();
    test_random_valid();
    test_no_wrap();
    test_saturation();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
